// File: rtl/updown_sweep_ctrl.sv
// Triangular lo->hi->lo sweep sequencer for an 8-bit up/down counter.
// Runs a programmed number of round trips, then pulses done.
module updown_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [CYC_W-1:0] cfg_trips,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] lo_q, hi_q;
  logic [CYC_W-1:0] trips_q, trips_done;
  logic             bad_cfg, at_hi, at_lo, last_trip;

  assign bad_cfg   = (cfg_lo >= cfg_hi) || (cfg_trips == '0);
  assign at_hi     = (count == hi_q);
  assign at_lo     = (count == lo_q);
  assign last_trip = ((trips_done + CYC_W'(1)) == trips_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && !bad_cfg) state_nx = UP;
      UP: begin
        if (stop)                state_nx = IDLE;
        else if (!pause && at_hi) state_nx = DOWN;
      end
      DOWN: begin
        if (stop) state_nx = IDLE;
        else if (!pause && at_lo)
          state_nx = last_trip ? IDLE : UP;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Counter, direction, trip bookkeeping and the one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      dir        <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      trips_done <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      trips_q    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (bad_cfg) begin
              err <= 1'b1;
            end else begin
              lo_q       <= cfg_lo;
              hi_q       <= cfg_hi;
              trips_q    <= cfg_trips;
              count      <= cfg_lo;
              dir        <= 1'b1;
              trips_done <= '0;
            end
          end
        end
        UP: begin
          if (stop) begin
            dir <= 1'b1;
          end else if (!pause) begin
            if (at_hi) begin
              count <= hi_q - 1'b1;
              dir   <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DOWN: begin
          if (stop) begin
            dir <= 1'b1;
          end else if (!pause) begin
            if (!at_lo) begin
              count <= count - 1'b1;
            end else if (last_trip) begin
              done <= 1'b1;
              dir  <= 1'b1;
            end else begin
              trips_done <= trips_done + 1'b1;
              count      <= lo_q + 1'b1;
              dir        <= 1'b1;
            end
          end
        end
        default: dir <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: position-based sweep model checked every
// cycle, plus directed literal expectations.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] cfg_lo = '0;
  logic [7:0] cfg_hi = '0;
  logic [3:0] cfg_trips = '0;
  logic [7:0] count;
  logic       dir, busy, done, err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_sweep_ctrl #(.WIDTH(8), .CYC_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_trips(cfg_trips),
    .count(count), .dir(dir), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = edges since accept; position in the triangle follows
  // from k, the span d = hi-lo and the trip count.
  bit         m_busy = 0;
  int         m_k = 0, m_lo = 0, m_hi = 0, m_trips = 0;
  int         md, mm;
  logic [7:0] m_count = '0;
  bit         m_dir = 1, m_done = 0, m_err = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_k = 0; m_lo = 0; m_hi = 0; m_trips = 0;
      m_count = '0; m_dir = 1; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err = 0;
      if (!m_busy) begin
        if (start) begin
          if (cfg_lo >= cfg_hi || cfg_trips == 0) begin
            m_err = 1;
          end else begin
            m_lo = int'(cfg_lo);
            m_hi = int'(cfg_hi);
            m_trips = int'(cfg_trips);
            m_k = 0;
            m_busy = 1;
            m_count = cfg_lo;
            m_dir = 1;
          end
        end
      end else if (stop) begin
        m_busy = 0;
        m_dir = 1;
      end else if (!pause) begin
        md = m_hi - m_lo;
        if (m_k == 2 * md * m_trips) begin
          m_busy = 0;
          m_done = 1;
          m_dir = 1;
          m_count = 8'(m_lo);
        end else begin
          m_k++;
          mm = ((m_k - 1) % (2 * md)) + 1;
          m_dir = (mm <= md);
          m_count = (mm <= md) ? 8'(m_lo + mm) : 8'(m_lo + 2 * md - mm);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model count", 32'(count), 32'(m_count));
      check("model dir", 32'(dir), 32'(m_dir));
      check("model busy", 32'(busy), 32'(m_busy));
      check("model done", 32'(done), 32'(m_done));
      check("model err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present config with start for one edge (edge 0), return at its negedge
  task automatic go(input int lo, input int hi, input int trips);
    cfg_lo = 8'(lo);
    cfg_hi = 8'(hi);
    cfg_trips = 4'(trips);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_count(input int v, input string name);
    int n;
    n = 0;
    while (count != 8'(v) && n < 600) begin
      tick();
      n++;
    end
    check(name, 32'(count), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seq1 [7] = '{2, 3, 4, 5, 4, 3, 2};
    int seq6 [7] = '{10, 11, 10, 11, 10, 11, 10};
    int blo [3] = '{7, 9, 2};
    int bhi [3] = '{7, 3, 5};
    int btr [3] = '{1, 1, 0};
    int n;
    logic [7:0] saved;

    #1 rst = 1'b1;
    tick();
    tick();
    check("reset count", 32'(count), 0);
    check("reset dir", 32'(dir), 1);
    check("reset busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // 2..5..2, one trip
    go(2, 5, 1);
    check("t1 edge0", 32'(count), 2);
    for (int i = 1; i < 7; i++) begin
      tick();
      check("t1 seq", 32'(count), 32'(seq1[i]));
    end
    tick();
    check("t1 done", 32'(done), 1);
    check("t1 busy", 32'(busy), 0);
    check("t1 count", 32'(count), 2);
    tick();
    check("t1 done pulse", 32'(done), 0);
    check("t1 hold", 32'(count), 2);

    // two trips
    go(2, 5, 2);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
      if (n == 3) check("t2 dir up", 32'(dir), 1);
      if (n == 4) check("t2 dir down", 32'(dir), 0);
      if (n == 7) check("t2 no repeat lo", 32'(count), 3);
      if (n == 7) check("t2 dir back up", 32'(dir), 1);
    end
    check("t2 done edge", 32'(n), 13);
    tick();

    // bad configs
    for (int i = 0; i < 3; i++) begin
      saved = count;
      go(blo[i], bhi[i], btr[i]);
      check("t3 err", 32'(err), 1);
      check("t3 busy", 32'(busy), 0);
      check("t3 count", 32'(count), 32'(saved));
      tick();
      check("t3 err pulse", 32'(err), 0);
    end

    // pause then stop on full range
    go(0, 255, 1);
    wait_count(100, "t4 reach 100");
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4 pause hold", 32'(count), 100);
    end
    pause = 1'b0;
    wait_count(200, "t4 reach 200");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4 stop busy", 32'(busy), 0);
    check("t4 stop count", 32'(count), 200);
    check("t4 no done", 32'(done), 0);
    tick();
    tick();

    // start/cfg changes while busy, then async reset in DOWN
    go(2, 5, 1);
    start = 1'b1;
    cfg_lo = 8'd0;
    cfg_hi = 8'd9;
    cfg_trips = 4'd5;
    tick();
    tick();
    tick();
    start = 1'b0;
    tick();
    check("t5 count edge4", 32'(count), 4);
    check("t5 dir edge4", 32'(dir), 0);
    #2 rst = 1'b1;
    #1;
    check("t5 async count", 32'(count), 0);
    check("t5 async dir", 32'(dir), 1);
    check("t5 async busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    tick();

    // minimal span, three trips
    go(10, 11, 3);
    check("t6 edge0", 32'(count), 10);
    n = 0;
    for (int i = 1; i < 7; i++) begin
      tick();
      check("t6 seq", 32'(count), 32'(seq6[i]));
    end
    tick();
    check("t6 done", 32'(done), 1);
    tick();

    // start accepted with stop high in IDLE; stop beats pause
    stop = 1'b1;
    go(10, 11, 3);
    stop = 1'b0;
    check("t6 start w stop", 32'(busy), 1);
    tick();
    stop = 1'b1;
    pause = 1'b1;
    tick();
    stop = 1'b0;
    pause = 1'b0;
    check("t6 stop wins", 32'(busy), 0);
    check("t6 stop count", 32'(count), 11);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
